// File: rtl/mem_write_buffer_if.sv
// Bus bundle between the CPU memory port, the write buffer and main memory.
// The buffer connects through the slave modport; the environment uses master.
interface mem_write_buffer_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16
);
    logic [BITS_ADDR-1:0] cpu_addr;
    logic [BITS_DATA-1:0] cpu_wdata;
    logic                 cpu_write;
    logic                 cpu_rd_req;
    logic [BITS_DATA-1:0] cpu_rdata;
    logic                 cpu_rd_valid;
    logic                 cpu_busy;
    logic                 overflow;
    logic                 mem_req;
    logic                 mem_we;
    logic [BITS_ADDR-1:0] mem_addr;
    logic [BITS_DATA-1:0] mem_wdata;
    logic                 mem_ack;
    logic [BITS_DATA-1:0] mem_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_write, cpu_rd_req, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_rd_valid, cpu_busy, overflow,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_write, cpu_rd_req, mem_ack, mem_rdata,
        output cpu_rdata, cpu_rd_valid, cpu_busy, overflow,
        output mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Posted-write buffer: CPU stores queue in a FIFO and drain to memory in order;
// reads forward the youngest buffered store or wait for the FIFO to empty.
module mem_write_buffer #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 16,
    parameter int DEPTH     = 4
) (
    input logic clk,
    input logic reset,
    mem_write_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WR_DRAIN, RD_MEM} stateT;

    stateT                state, stateNext;
    logic [BITS_ADDR-1:0] fifoAddr [DEPTH];
    logic [BITS_DATA-1:0] fifoData [DEPTH];
    logic [PTR_W-1:0]     wrPtr, rdPtr, scanIdx;
    logic [CW-1:0]        count, countNext;
    logic                 cpuWritePrev, writeEdge, doPush, doPop;
    logic                 rdAccept, rdHit, rdPending, rdPendingNext, startRead;
    logic [BITS_ADDR-1:0] rdAddr;
    logic [BITS_DATA-1:0] hitData, rdData;
    logic                 rdValid, busy, overflowReg;
    logic                 memReq, memWe;
    logic [BITS_ADDR-1:0] memAddr;
    logic [BITS_DATA-1:0] memWdata;

    assign writeEdge = bus.cpu_write & ~cpuWritePrev;
    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    assign doPush    = writeEdge && (count != FULL);
    assign doPop     = (state == WR_DRAIN) && bus.mem_ack;
    assign rdAccept  = bus.cpu_rd_req && !rdPending && (state != RD_MEM);
    assign startRead = (state == IDLE) && rdPending && (count == '0);

    // NOTE: every variable gets a default at the top of an always_comb so no latch is inferred.
    always_comb begin
        countNext = count;
        if (doPush && !doPop)      countNext = count + CW'(1);
        else if (!doPush && doPop) countNext = count - CW'(1);
    end

    // Scan oldest to youngest so the last match wins; a same-cycle push is youngest of all.
    always_comb begin
        rdHit   = 1'b0;
        hitData = '0;
        scanIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = rdPtr + PTR_W'(i);
            if ((CW'(i) < count) && (fifoAddr[scanIdx] == bus.cpu_addr)) begin
                rdHit   = 1'b1;
                hitData = fifoData[scanIdx];
            end
        end
        if (doPush) begin
            rdHit   = 1'b1;
            hitData = bus.cpu_wdata;
        end
    end

    always_comb begin
        rdPendingNext = rdPending;
        if (rdAccept && !rdHit) rdPendingNext = 1'b1;
        if (startRead)          rdPendingNext = 1'b0;
    end

    always_comb begin
        stateNext = state;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWdata  = '0;
        case (state)
            IDLE: begin
                if (startRead)           stateNext = RD_MEM;
                else if (count != '0)    stateNext = WR_DRAIN;
            end
            WR_DRAIN: begin
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = fifoAddr[rdPtr];
                memWdata = fifoData[rdPtr];
                if (bus.mem_ack && (countNext == '0)) stateNext = IDLE;
            end
            RD_MEM: begin
                memReq  = 1'b1;
                memAddr = rdAddr;
                if (bus.mem_ack) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            cpuWritePrev <= 1'b0;
            rdPending    <= 1'b0;
            rdAddr       <= '0;
            rdData       <= '0;
            rdValid      <= 1'b0;
            busy         <= 1'b0;
            overflowReg  <= 1'b0;
        end else begin
            state        <= stateNext;
            count        <= countNext;
            cpuWritePrev <= bus.cpu_write;
            rdPending    <= rdPendingNext;
            busy         <= (countNext == FULL) | rdPendingNext | (stateNext == RD_MEM);
            rdValid      <= 1'b0;
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            if (writeEdge && (count == FULL)) overflowReg <= 1'b1;
            if (rdAccept && !rdHit) rdAddr <= bus.cpu_addr;
            if (rdAccept && rdHit) begin
                rdData  <= hitData;
                rdValid <= 1'b1;
            end else if ((state == RD_MEM) && bus.mem_ack) begin
                rdData  <= bus.mem_rdata;
                rdValid <= 1'b1;
            end
        end
    end

    // NOTE: storage needs no reset; count gates which entries are valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoAddr[wrPtr] <= bus.cpu_addr;
            fifoData[wrPtr] <= bus.cpu_wdata;
        end
    end

    assign bus.cpu_rdata    = rdData;
    assign bus.cpu_rd_valid = rdValid;
    assign bus.cpu_busy     = busy;
    assign bus.overflow     = overflowReg;
    assign bus.mem_req      = memReq;
    assign bus.mem_we       = memWe;
    assign bus.mem_addr     = memAddr;
    assign bus.mem_wdata    = memWdata;
endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: a small memory responder logs every completed
// access as {we, addr, data}; directed steps compare outputs against hand-computed values.
module tb_mem_write_buffer;
    localparam int BITS_DATA = 32;
    localparam int BITS_ADDR = 16;
    localparam int DEPTH     = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_write_buffer_if #(.BITS_DATA(BITS_DATA), .BITS_ADDR(BITS_ADDR)) bus ();

    mem_write_buffer #(.BITS_DATA(BITS_DATA), .BITS_ADDR(BITS_ADDR), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic        ackEn    = 1'b0;
    logic        ackAlt   = 1'b0;
    logic        phase    = 1'b0;
    logic [31:0] memRdata = 32'h0;
    int          errors   = 0;
    int          checks   = 0;
    int          cycleCnt = 0;
    int          readAckCycle = -1;
    logic [48:0] memLog [$];

    assign bus.mem_ack   = bus.mem_req & (ackEn | (ackAlt & phase));
    assign bus.mem_rdata = memRdata;

    always @(posedge clk) begin
        phase <= ~phase;
        cycleCnt = cycleCnt + 1;
        if (reset && bus.mem_req && bus.mem_ack) begin
            memLog.push_back({bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : bus.mem_rdata});
            if (!bus.mem_we) readAckCycle = cycleCnt;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [31:0] d);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_write = 1'b1;
        tick();
        bus.cpu_write = 1'b0;
        tick();
    endtask

    task automatic doReset();
        ackEn  = 1'b0;
        ackAlt = 1'b0;
        bus.cpu_write  = 1'b0;
        bus.cpu_rd_req = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        memLog.delete();
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (((dut.count != 0) || bus.mem_req) && (n < 200)) begin
            tick();
            n++;
        end
        check(tag, 64'(n < 200), 64'd1);
    endtask

    initial begin
        int n;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.cpu_write  = 1'b0;
        bus.cpu_rd_req = 1'b0;
        tick(2);
        reset = 1'b1;

        // Reset state
        check("rst_mem_req",  bus.mem_req, 0);
        check("rst_busy",     bus.cpu_busy, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_rd_valid", bus.cpu_rd_valid, 0);
        check("rst_count",    dut.count, 0);

        // Reset mid-drain
        push(16'h1000, 32'h11111111);
        push(16'h1001, 32'h22222222);
        push(16'h1002, 32'h33333333);
        check("t1_drain_req",  bus.mem_req, 1);
        check("t1_drain_we",   bus.mem_we, 1);
        check("t1_drain_addr", bus.mem_addr, 16'h1000);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t1_req_after_rst",   bus.mem_req, 0);
        check("t1_count_after_rst", dut.count, 0);
        check("t1_ovf_after_rst",   bus.overflow, 0);
        ackEn = 1'b1;
        tick(6);
        check("t1_no_writes", memLog.size(), 0);
        check("t1_req_idle",  bus.mem_req, 0);

        // Level-held cpu_write gives a single push
        doReset();
        bus.cpu_addr  = 16'h0040;
        bus.cpu_wdata = 32'h00000066;
        bus.cpu_write = 1'b1;
        tick(3);
        bus.cpu_write = 1'b0;
        tick();
        check("t6_count", dut.count, 1);
        ackEn = 1'b1;
        waitDrain("t6_drain_timeout");
        check("t6_writes", memLog.size(), 1);
        check("t6_entry",  memLog[0], {1'b1, 16'h0040, 32'h00000066});

        // Forwarding: youngest buffered store wins, memory stays on the write
        doReset();
        push(16'h0010, 32'hAAAA0001);
        push(16'h0010, 32'hBBBB0002);
        bus.cpu_addr   = 16'h0010;
        bus.cpu_rd_req = 1'b1;
        tick();
        bus.cpu_rd_req = 1'b0;
        check("t3_rd_valid", bus.cpu_rd_valid, 1);
        check("t3_rdata",    bus.cpu_rdata, 32'hBBBB0002);
        check("t3_mem_we",   bus.mem_we, 1);
        check("t3_mem_data", bus.mem_wdata, 32'hAAAA0001);
        tick();
        check("t3_rd_pulse", bus.cpu_rd_valid, 0);
        check("t3_busy",     bus.cpu_busy, 0);
        bus.cpu_addr   = 16'h0050;
        bus.cpu_wdata  = 32'h00000077;
        bus.cpu_write  = 1'b1;
        bus.cpu_rd_req = 1'b1;
        tick();
        bus.cpu_write  = 1'b0;
        bus.cpu_rd_req = 1'b0;
        check("t3_samecyc_valid", bus.cpu_rd_valid, 1);
        check("t3_samecyc_rdata", bus.cpu_rdata, 32'h00000077);
        ackEn = 1'b1;
        waitDrain("t3_drain_timeout");
        check("t3_writes", memLog.size(), 3);
        check("t3_last",   memLog[2], {1'b1, 16'h0050, 32'h00000077});

        // Ordering: miss waits behind the buffered write
        doReset();
        memRdata = 32'hCAFEF00D;
        push(16'h0020, 32'h12345678);
        bus.cpu_addr   = 16'h0030;
        bus.cpu_rd_req = 1'b1;
        tick();
        bus.cpu_rd_req = 1'b0;
        check("t4_busy_pending", bus.cpu_busy, 1);
        check("t4_no_valid",     bus.cpu_rd_valid, 0);
        check("t4_still_write",  bus.mem_we, 1);
        ackEn = 1'b1;
        n = 0;
        while (!bus.cpu_rd_valid && (n < 50)) begin
            tick();
            n++;
        end
        check("t4_rd_timeout", 64'(n < 50), 1);
        check("t4_rdata",      bus.cpu_rdata, 32'hCAFEF00D);
        check("t4_latency",    cycleCnt, readAckCycle);
        check("t4_ops",        memLog.size(), 2);
        check("t4_first",      memLog[0], {1'b1, 16'h0020, 32'h12345678});
        check("t4_second",     memLog[1], {1'b0, 16'h0030, 32'hCAFEF00D});
        tick();
        check("t4_busy_clear", bus.cpu_busy, 0);

        // Wrap: 10 pushes with memory acking every other cycle
        doReset();
        ackAlt = 1'b1;
        for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i), 32'hD0000000 + 32'(i));
        waitDrain("t5_drain_timeout");
        check("t5_writes", memLog.size(), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("t5_entry%0d", i), memLog[i], {1'b1, 16'h0100 + 16'(i), 32'hD0000000 + 32'(i)});
        check("t5_overflow", bus.overflow, 0);
        check("t5_wrptr",    dut.wrPtr, 2);
        check("t5_rdptr",    dut.rdPtr, 2);

        // Same-cycle push and pop keeps count
        doReset();
        push(16'h0200, 32'h00000001);
        push(16'h0201, 32'h00000002);
        bus.cpu_addr  = 16'h0202;
        bus.cpu_wdata = 32'h00000003;
        bus.cpu_write = 1'b1;
        ackEn = 1'b1;
        tick();
        ackEn = 1'b0;
        bus.cpu_write = 1'b0;
        check("t5_pp_count", dut.count, 2);
        check("t5_pp_pop",   memLog.size(), 1);
        check("t5_pp_head",  bus.mem_addr, 16'h0201);
        ackEn = 1'b1;
        waitDrain("t5_pp_timeout");
        check("t5_pp_last", memLog[2], {1'b1, 16'h0202, 32'h00000003});

        // Fill and overflow with memory stalled
        doReset();
        for (int i = 0; i < 4; i++) push(16'h0300 + 16'(i), 32'h000000E0 + 32'(i));
        check("t2_busy_full", bus.cpu_busy, 1);
        check("t2_no_ovf",    bus.overflow, 0);
        push(16'h03FF, 32'hDEADBEEF);
        check("t2_ovf",       bus.overflow, 1);
        check("t2_count",     dut.count, 4);
        ackEn = 1'b1;
        waitDrain("t2_drain_timeout");
        check("t2_writes", memLog.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_entry%0d", i), memLog[i], {1'b1, 16'h0300 + 16'(i), 32'h000000E0 + 32'(i)});
        check("t2_ovf_sticky", bus.overflow, 1);
        check("t2_busy_clear", bus.cpu_busy, 0);

        // Full is decided on the registered count even with a same-cycle pop
        doReset();
        for (int i = 0; i < 4; i++) push(16'h0300 + 16'(i), 32'h000000F0 + 32'(i));
        bus.cpu_addr  = 16'h003A;
        bus.cpu_wdata = 32'h000000AB;
        bus.cpu_write = 1'b1;
        ackEn = 1'b1;
        tick();
        ackEn = 1'b0;
        bus.cpu_write = 1'b0;
        check("ovfpop_ovf",   bus.overflow, 1);
        check("ovfpop_count", dut.count, 3);
        ackEn = 1'b1;
        waitDrain("ovfpop_timeout");
        check("ovfpop_writes", memLog.size(), 4);
        check("ovfpop_last",   memLog[3], {1'b1, 16'h0303, 32'h000000F3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
